// File: rtl/bullet_pool_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool_ctrl_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the bullet pool
// Revision : 1.0 - initial release
// ============================================================================
package bullet_pool_ctrl_pkg;

  // Coordinate width shared by x and y
  localparam int c_COORD_W = 12;

  // Requester indices
  localparam int c_NUM_REQ    = 2;
  localparam int c_REQ_PLAYER = 0;
  localparam int c_REQ_ENEMY  = 1;

  // Owner direction: player bullets travel up, enemy bullets travel down
  localparam logic c_OWNER_UP   = 1'b0;
  localparam logic c_OWNER_DOWN = 1'b1;

  // Frame sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE    = 2'd0;
  localparam state_t c_ST_MOVE    = 2'd1;
  localparam state_t c_ST_ALLOC_A = 2'd2;
  localparam state_t c_ST_ALLOC_B = 2'd3;

  // Extract one requester's coordinate from a packed two-requester bus
  function automatic logic [c_COORD_W-1:0] req_coord(
    input logic [2*c_COORD_W-1:0] i_bus,
    input logic                   i_sel
  );
    return (i_sel == 1'(c_REQ_ENEMY)) ? i_bus[2*c_COORD_W-1:c_COORD_W]
                                      : i_bus[c_COORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module   : bullet_slot
// Purpose  : One bullet slot register with load, kill and per-frame move
// Revision : 1.0 - initial release
// ============================================================================
module bullet_slot
  import bullet_pool_ctrl_pkg::*;
#(
  parameter int SPEED    = 4,
  parameter int B_SIZE   = 4,
  parameter int SCREEN_H = 480
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_move,
  input  logic                 i_kill,
  input  logic                 i_load,
  input  logic                 i_load_owner,
  input  logic [c_COORD_W-1:0] i_load_x,
  input  logic [c_COORD_W-1:0] i_load_y,
  output logic                 o_valid,
  output logic                 o_owner,
  output logic [c_COORD_W-1:0] o_x,
  output logic [c_COORD_W-1:0] o_y
);

  // One extra bit so the downward retire compare cannot overflow
  localparam logic [c_COORD_W:0]   c_STEP_X = (c_COORD_W+1)'(SPEED);
  localparam logic [c_COORD_W:0]   c_LIMIT  = (c_COORD_W+1)'(SCREEN_H - B_SIZE);
  localparam logic [c_COORD_W-1:0] c_STEP   = c_COORD_W'(SPEED);

  logic                 r_valid;
  logic                 r_owner;
  logic [c_COORD_W-1:0] r_x;
  logic [c_COORD_W-1:0] r_y;

  logic [c_COORD_W:0]   w_y_ext;
  logic                 w_retire;
  logic [c_COORD_W-1:0] w_y_next;

  // Retire test and next position depend only on travel direction
  always_comb begin
    w_y_ext = {1'b0, r_y};
    if (r_owner == c_OWNER_UP) begin
      w_retire = (w_y_ext < c_STEP_X);
      w_y_next = r_y - c_STEP;
    end else begin
      w_retire = ((w_y_ext + c_STEP_X) > c_LIMIT);
      w_y_next = r_y + c_STEP;
    end
  end

  // Load wins over kill (a killed slot may be re-used the same cycle); kill wins over move
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_owner <= c_OWNER_UP;
      r_x     <= '0;
      r_y     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_owner <= i_load_owner;
      r_x     <= i_load_x;
      r_y     <= i_load_y;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_move && r_valid) begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end else begin
        r_y <= w_y_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_owner = r_owner;
  assign o_x     = r_x;
  assign o_y     = r_y;

endmodule
`default_nettype wire

// File: rtl/bullet_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool_ctrl
// Purpose  : Bullet slot pool with round-robin fire arbitration, per-frame
//            movement, retire and collision kill
// Revision : 1.0 - initial release
// ============================================================================
module bullet_pool_ctrl
  import bullet_pool_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SPEED     = 4,
  parameter int B_SIZE    = 4,
  parameter int SCREEN_H  = 480,
  parameter int COOLDOWN  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_ani_stb,
  input  logic                           i_animate,
  input  logic [c_NUM_REQ-1:0]           i_req,
  input  logic [2*c_COORD_W-1:0]         i_req_x,
  input  logic [2*c_COORD_W-1:0]         i_req_y,
  input  logic [NUM_SLOTS-1:0]           i_kill,
  output logic [c_NUM_REQ-1:0]           o_gnt,
  output logic                           o_full,
  output logic [NUM_SLOTS-1:0]           o_bvalid,
  output logic [NUM_SLOTS-1:0]           o_bowner,
  output logic [NUM_SLOTS*c_COORD_W-1:0] o_bx,
  output logic [NUM_SLOTS*c_COORD_W-1:0] o_by
);

  localparam int c_IDX_W = $clog2(NUM_SLOTS);
  localparam int c_CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN);

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_rr;
  logic                 r_frame_gnt;
  logic [c_NUM_REQ-1:0] r_gnt;
  logic [c_CD_W-1:0]    r_cd [c_NUM_REQ];

  logic                 w_tick;
  logic                 w_move;
  logic                 w_alloc;
  logic                 w_alloc_a;
  logic                 w_alloc_b;
  logic                 w_sel;
  logic                 w_elig;
  logic [NUM_SLOTS-1:0] w_valid;
  logic [NUM_SLOTS-1:0] w_free;
  logic [NUM_SLOTS-1:0] w_load;
  logic [c_IDX_W-1:0]   w_slot_idx;
  logic [c_COORD_W-1:0] w_spawn_x;
  logic [c_COORD_W-1:0] w_spawn_y;

  assign w_tick = i_ani_stb & i_animate;

  // Frame sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencer next state; ticks outside IDLE are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_tick) w_state_nxt = c_ST_MOVE;
      c_ST_MOVE:    w_state_nxt = c_ST_ALLOC_A;
      c_ST_ALLOC_A: w_state_nxt = c_ST_ALLOC_B;
      c_ST_ALLOC_B: w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Frame sequencer decoded controls; ALLOC_A serves rr, ALLOC_B the other requester
  always_comb begin
    w_move    = (r_state == c_ST_MOVE);
    w_alloc_a = (r_state == c_ST_ALLOC_A);
    w_alloc_b = (r_state == c_ST_ALLOC_B);
    w_alloc   = w_alloc_a | w_alloc_b;
    w_sel     = w_alloc_a ? r_rr : ~r_rr;
  end

  // A slot being killed this cycle already counts as free
  assign w_free = ~w_valid | i_kill;

  // Lowest-index free slot priority encoder
  always_comb begin
    w_slot_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) w_slot_idx = c_IDX_W'(i);
    end
  end

  assign w_elig    = w_alloc & i_req[w_sel] & (r_cd[w_sel] == '0) & (|w_free);
  assign w_load    = w_elig ? (NUM_SLOTS'(1) << w_slot_idx) : '0;
  assign w_spawn_x = req_coord(i_req_x, w_sel);
  assign w_spawn_y = req_coord(i_req_y, w_sel);

  // Grant pulse, one cycle after the serving allocation cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt <= '0;
    end else begin
      r_gnt <= w_elig ? (c_NUM_REQ'(1) << w_sel) : '0;
    end
  end

  // Round-robin pointer flips once per frame that produced any grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr        <= 1'b0;
      r_frame_gnt <= 1'b0;
    end else begin
      if (w_alloc_a) r_frame_gnt <= w_elig;
      if (w_alloc_b && (r_frame_gnt || w_elig)) r_rr <= ~r_rr;
    end
  end

  // Per-requester cooldown: counts down once per frame, reloaded on grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < c_NUM_REQ; r++) r_cd[r] <= '0;
    end else begin
      for (int r = 0; r < c_NUM_REQ; r++) begin
        if (w_move && (r_cd[r] != '0)) begin
          r_cd[r] <= r_cd[r] - 1'b1;
        end else if (w_elig && (w_sel == 1'(r))) begin
          r_cd[r] <= c_CD_LOAD;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      bullet_slot #(
        .SPEED    (SPEED),
        .B_SIZE   (B_SIZE),
        .SCREEN_H (SCREEN_H)
      ) u_slot (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_move       (w_move),
        .i_kill       (i_kill[k]),
        .i_load       (w_load[k]),
        .i_load_owner (w_sel),
        .i_load_x     (w_spawn_x),
        .i_load_y     (w_spawn_y),
        .o_valid      (w_valid[k]),
        .o_owner      (o_bowner[k]),
        .o_x          (o_bx[k*c_COORD_W +: c_COORD_W]),
        .o_y          (o_by[k*c_COORD_W +: c_COORD_W])
      );
    end
  endgenerate

  assign o_gnt    = r_gnt;
  assign o_bvalid = w_valid;
  assign o_full   = &w_valid;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_pool_ctrl
// Purpose  : Self-checking bench for bullet_pool_ctrl (default build plus a
//            zero-cooldown build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_pool_ctrl;

  localparam int NS  = 4;
  localparam int SPD = 4;
  localparam int BSZ = 4;
  localparam int SH  = 480;
  localparam int CD  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              ani, anim;
  logic [1:0]        req, req2;
  logic [23:0]       rx, ry, rx2, ry2;
  logic [NS-1:0]     kill, kill2;
  logic [1:0]        gnt, gnt2;
  logic              full, full2;
  logic [NS-1:0]     bvalid, bowner, bvalid2, bowner2;
  logic [NS*12-1:0]  bx, by, bx2, by2;

  bullet_pool_ctrl #(.NUM_SLOTS(NS), .SPEED(SPD), .B_SIZE(BSZ), .SCREEN_H(SH), .COOLDOWN(CD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani), .i_animate(anim),
    .i_req(req), .i_req_x(rx), .i_req_y(ry), .i_kill(kill),
    .o_gnt(gnt), .o_full(full), .o_bvalid(bvalid), .o_bowner(bowner),
    .o_bx(bx), .o_by(by)
  );

  bullet_pool_ctrl #(.NUM_SLOTS(NS), .SPEED(SPD), .B_SIZE(BSZ), .SCREEN_H(SH), .COOLDOWN(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani), .i_animate(anim),
    .i_req(req2), .i_req_x(rx2), .i_req_y(ry2), .i_kill(kill2),
    .o_gnt(gnt2), .o_full(full2), .o_bvalid(bvalid2), .o_bowner(bowner2),
    .o_bx(bx2), .o_by(by2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame-level) ----------------
  bit         m_valid [NS];
  bit         m_owner [NS];
  int         m_x [NS];
  int         m_y [NS];
  int         m_cd [2];
  bit         m_rr;
  logic [1:0] m_gnt;
  bit         chk_en;

  // Results of the most recent frame as seen on the DUT pins
  logic [1:0] d_ga, d_gb;
  int         d2_cnt;

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd[0] = 0; m_cd[1] = 0; m_rr = 0; m_gnt = 2'b00;
  endtask

  task automatic m_move();
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i]) begin
        if (!m_owner[i]) begin
          if (m_y[i] < SPD) m_valid[i] = 0; else m_y[i] = m_y[i] - SPD;
        end else begin
          if (m_y[i] + SPD > SH - BSZ) m_valid[i] = 0; else m_y[i] = m_y[i] + SPD;
        end
      end
    end
    for (int r = 0; r < 2; r++) if (m_cd[r] > 0) m_cd[r] = m_cd[r] - 1;
  endtask

  task automatic m_serve(input int r, output logic [1:0] g);
    int s;
    g = 2'b00;
    s = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) s = i;
    if (req[r] && m_cd[r] == 0 && s >= 0) begin
      m_valid[s] = 1;
      m_owner[s] = (r == 1);
      m_x[s]     = int'(rx[r*12 +: 12]);
      m_y[s]     = int'(ry[r*12 +: 12]);
      m_cd[r]    = CD;
      g[r]       = 1'b1;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    logic [NS-1:0]    ev, eo;
    logic [NS*12-1:0] ex, ey;
    if (chk_en) begin
      for (int i = 0; i < NS; i++) begin
        ev[i] = m_valid[i];
        eo[i] = m_owner[i];
        ex[i*12 +: 12] = 12'(m_x[i]);
        ey[i*12 +: 12] = 12'(m_y[i]);
      end
      check("bvalid", bvalid, ev);
      check("bowner", bowner, eo);
      check("bx", bx, ex);
      check("by", by, ey);
      check("gnt", gnt, m_gnt);
      check("full", full, &ev);
    end
  end

  // One frame: tick, MOVE, ALLOC_A, ALLOC_B, then two idle cycles.
  // hold marks requesters that keep requesting after being granted.
  task automatic run_frame(input logic [1:0] hold);
    logic [1:0] ga, gb;
    int a;
    d2_cnt = 0;
    ani = 1'b1; anim = 1'b1;
    @(posedge clk); #1;                 // MOVE
    ani = 1'b0; anim = 1'b0;
    @(posedge clk); #1;                 // ALLOC_A, moved positions visible
    m_move();
    a = int'(m_rr);
    @(posedge clk); #1;                 // ALLOC_B, first service visible
    m_serve(a, ga);
    m_gnt = ga;
    d_ga = gnt;
    if (gnt2 != 2'b00) d2_cnt++;
    @(posedge clk); #1;                 // IDLE, second service visible
    m_serve(1 - a, gb);
    m_gnt = gb;
    d_gb = gnt;
    if (gnt2 != 2'b00) d2_cnt++;
    if ((ga | gb) != 2'b00) m_rr = ~m_rr;
    req = req & ~((ga | gb) & ~hold);
    @(posedge clk); #1;
    m_gnt = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic kill_slots(input logic [NS-1:0] k);
    kill = k;
    @(posedge clk); #1;
    kill = '0;
    for (int i = 0; i < NS; i++) if (k[i]) m_valid[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gf [$];
    rst_n = 1'b0; ani = 1'b0; anim = 1'b0;
    req = '0; rx = '0; ry = '0; kill = '0;
    req2 = '0; rx2 = '0; ry2 = '0; kill2 = '0;
    chk_en = 0; d_ga = '0; d_gb = '0; d2_cnt = 0;
    m_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", bvalid, 0);
    check("rst_gnt", gnt, 0);
    check("rst_by", by, 0);
    check("rst_full", full, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;

    // Reset asserted during ALLOC_A aborts the frame: no load, no grant
    req = 2'b01; rx[11:0] = 12'd100; ry[11:0] = 12'd10;
    ani = 1'b1; anim = 1'b1;
    @(posedge clk); #1;
    ani = 1'b0; anim = 1'b0;
    @(posedge clk); #1;                 // ALLOC_A
    chk_en = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_bvalid", bvalid, 0);
    @(posedge clk); #1;
    check("abort_gnt", gnt, 0);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    chk_en = 1;

    // First frame after reset: player spawn at (100,10), grant at tick+3
    run_frame(2'b00);
    check("first_gnt_tick3", d_ga, 2'b01);
    check("first_slot0", {bvalid[0], bx[11:0], by[11:0]}, {1'b1, 12'd100, 12'd10});

    // Player bullet path 10 -> 6 -> 2 -> retired
    run_frame(2'b00);
    check("player_y6", by[11:0], 12'd6);
    run_frame(2'b00);
    check("player_y2", by[11:0], 12'd2);
    run_frame(2'b00);
    check("player_retired", bvalid[0], 1'b0);

    // Enemy bullet path 470 -> 474 -> retired (478 > 476); rr now favours requester 1
    req = 2'b10; rx[23:12] = 12'd200; ry[23:12] = 12'd470;
    run_frame(2'b00);
    check("enemy_gnt_first", d_ga, 2'b10);
    check("enemy_spawn", {bowner[0], by[11:0]}, {1'b1, 12'd470});
    run_frame(2'b00);
    check("enemy_y474", by[11:0], 12'd474);
    run_frame(2'b00);
    check("enemy_retired", bvalid[0], 1'b0);

    // Let both cooldowns expire, then simultaneous requests with rr = 0
    repeat (8) run_frame(2'b00);
    req = 2'b11; rx = {12'd60, 12'd50}; ry = {12'd100, 12'd300};
    run_frame(2'b00);
    check("sim_gnt_a", d_ga, 2'b01);
    check("sim_gnt_b", d_gb, 2'b10);
    check("sim_owner", bowner[1:0], 2'b10);

    // Next contested frame serves requester 1 first
    repeat (8) run_frame(2'b00);
    req = 2'b11; rx = {12'd80, 12'd70}; ry = {12'd200, 12'd400};
    run_frame(2'b00);
    check("rr_gnt_a", d_ga, 2'b10);
    check("rr_gnt_b", d_gb, 2'b01);
    check("rr_owner", bowner[3:2], 2'b01);
    check("pool_full", full, 1'b1);

    // Pool full: player keeps requesting, nothing granted
    req = 2'b01; rx[11:0] = 12'd90; ry[11:0] = 12'd350;
    for (int f = 0; f < 9; f++) begin
      run_frame(2'b01);
      check("full_no_gnt", d_ga | d_gb, 2'b00);
    end
    kill_slots(4'b0100);
    check("kill_slot2", bvalid, 4'b1011);
    check("kill_not_full", full, 1'b0);
    run_frame(2'b00);
    check("refill_gnt", d_ga | d_gb, 2'b01);
    check("refill_slot2", {bvalid[2], bowner[2], bx[35:24], by[35:24]},
          {1'b1, 1'b0, 12'd90, 12'd350});

    // Cooldown 8: continuous request gives grants COOLDOWN frames apart
    kill_slots(4'b1111);
    req = 2'b01; rx[11:0] = 12'd20; ry[11:0] = 12'd440;
    for (int f = 0; f < 20; f++) begin
      run_frame(2'b01);
      if ((d_ga | d_gb) != 2'b00) gf.push_back(f);
    end
    check("cd_grant_count", gf.size(), 2);
    if (gf.size() >= 2) check("cd_interval", gf[1] - gf[0], CD);
    req = 2'b00;

    // Cooldown disabled: a grant every frame until the pool is full
    req2 = 2'b01; rx2[11:0] = 12'd10; ry2[11:0] = 12'd400;
    for (int f = 0; f < 5; f++) begin
      run_frame(2'b00);
      check("nocd_gnt_per_frame", d2_cnt, (f < 4) ? 1 : 0);
    end
    check("nocd_full", full2, 1'b1);
    check("nocd_valid", bvalid2, 4'b1111);
    check("nocd_owner", bowner2, 4'b0000);
    check("nocd_slot0", {bx2[11:0], by2[11:0]}, {12'd10, 12'd384});
    req2 = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
